// File: rtl/gc_joybus_tx.sv
// GameCube joybus transmitter: serialises a left-aligned command word into 4 us
// bit cells, appends the stop bit and a guard interval, driving an open-drain pad.
module gc_joybus_tx #(
    parameter int CLKS_PER_US = 16,
    parameter int DATA_W      = 24,
    parameter int GUARD_US    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        start,
    input  logic [$clog2(DATA_W+1)-1:0] tx_len,
    input  logic [DATA_W-1:0]           tx_data,
    output logic                        drive_low,
    output logic                        busy,
    output logic                        done
);

    localparam int LEN_W  = $clog2(DATA_W + 1);
    localparam int US_W   = $clog2(CLKS_PER_US);
    localparam int PH_MAX = (GUARD_US > 4) ? GUARD_US : 4;
    localparam int PH_W   = $clog2(PH_MAX);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, STOP_LOW, GUARD} state_t;

    state_t             state, state_nx;
    logic [US_W-1:0]    us_cnt;
    logic [PH_W-1:0]    phase_us;
    logic [DATA_W-1:0]  shreg;
    logic [LEN_W-1:0]   bits_left;
    logic [LEN_W-1:0]   len_clamped;
    logic               accept, us_tick, cell_end;
    logic [PH_W-1:0]    low_last, high_last;

    assign len_clamped = (tx_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : tx_len;
    assign accept      = (state == IDLE) && start && enable;
    assign us_tick     = (us_cnt == US_W'(CLKS_PER_US - 1));
    // A '1' cell is 1 us low / 3 us high, a '0' cell the reverse.
    assign low_last    = shreg[DATA_W-1] ? PH_W'(0) : PH_W'(2);
    assign high_last   = shreg[DATA_W-1] ? PH_W'(2) : PH_W'(0);
    assign cell_end    = (state == HIGH) && us_tick && (phase_us == high_last);

    always_comb begin
        state_nx  = state;
        drive_low = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nx = (len_clamped == '0) ? STOP_LOW : LOW;
            end
            LOW: begin
                drive_low = 1'b1;
                if (us_tick && (phase_us == low_last))
                    state_nx = HIGH;
            end
            HIGH: begin
                if (cell_end)
                    state_nx = (bits_left == LEN_W'(1)) ? STOP_LOW : LOW;
            end
            STOP_LOW: begin
                drive_low = 1'b1;
                if (us_tick)
                    state_nx = GUARD;
            end
            GUARD: begin
                if (us_tick && (phase_us == PH_W'(GUARD_US - 1))) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            us_cnt    <= '0;
            phase_us  <= '0;
            bits_left <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                bits_left <= len_clamped;
                us_cnt    <= '0;
                phase_us  <= '0;
            end else if (state != IDLE) begin
                us_cnt <= us_tick ? '0 : us_cnt + US_W'(1);
                // Phase boundaries always coincide with a microsecond wrap.
                if (state_nx != state)
                    phase_us <= '0;
                else if (us_tick)
                    phase_us <= phase_us + PH_W'(1);
                if (cell_end)
                    bits_left <= bits_left - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            shreg <= tx_data;
        else if (cell_end)
            shreg <= shreg << 1;
    end

endmodule

// File: tb/tb_gc_joybus_tx.sv
// Self-checking bench for gc_joybus_tx: compares every cycle of each frame against
// a waveform built directly from the bit-cell timing rules.
module tb_gc_joybus_tx;

    localparam int CUS   = 4;
    localparam int DW    = 24;
    localparam int GUS   = 2;
    localparam int LEN_W = $clog2(DW + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] tx_len = '0;
    logic [DW-1:0]    tx_data = '0;
    logic             drive_low, busy, done;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    gc_joybus_tx #(.CLKS_PER_US(CUS), .DATA_W(DW), .GUARD_US(GUS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start),
        .tx_len(tx_len), .tx_data(tx_data),
        .drive_low(drive_low), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected drive_low for cycles 1..N after accept.
    function automatic void build_wave(input logic [DW-1:0] data, input int len);
        int n;
        int low_us;
        exp_q.delete();
        n = (len > DW) ? DW : len;
        for (int i = 0; i < n; i++) begin
            low_us = data[DW-1-i] ? 1 : 3;
            for (int c = 0; c < 4 * CUS; c++)
                exp_q.push_back(c < low_us * CUS);
        end
        for (int c = 0; c < CUS; c++) exp_q.push_back(1'b1);
        for (int c = 0; c < GUS * CUS; c++) exp_q.push_back(1'b0);
    endfunction

    // Starts a frame from the current cycle and checks it to the first idle cycle.
    // inj_at: cycle in which a competing start with other data is driven (0 = none).
    task automatic send(input logic [DW-1:0] data, input int len, input string name,
                        input int inj_at, input bit drop_enable, input bit start_in_done);
        int n;
        int bad;
        bad = 0;
        build_wave(data, len);
        n = exp_q.size();
        tx_data = data;
        tx_len  = LEN_W'(len);
        enable  = 1'b1;
        start   = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start   = ((k == inj_at) || (start_in_done && k == n)) ? 1'b1 : 1'b0;
            tx_data = DW'($urandom);
            tx_len  = LEN_W'($urandom_range(0, DW));
            if (drop_enable) enable = 1'b0;
            @(negedge clk);
            checks++;
            if (drive_low !== exp_q[k-1] || busy !== 1'b1 || done !== (k == n)) begin
                errors++;
                if (bad < 4)
                    $display("FAIL %s cycle %0d: drive_low=%b busy=%b done=%b, expected %b 1 %b",
                             name, k, drive_low, busy, done, exp_q[k-1], (k == n));
                bad++;
            end
        end
        @(posedge clk); #1;
        start  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (drive_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: drive_low=%b busy=%b done=%b, expected 0 0 0",
                     name, drive_low, busy, done);
        end
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (drive_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s: drive_low=%b busy=%b done=%b, expected 0 0 0",
                         name, drive_low, busy, done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (drive_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: drive_low=%b busy=%b done=%b, expected 0 0 0",
                     drive_low, busy, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_bits();
        send(24'h000000, 1, "t1_bit0", 0, 0, 0);
        send(24'h800000, 1, "t2_bit1", 0, 0, 0);
        send(24'h000000, 0, "len0", 0, 0, 0);
    endtask

    task automatic test_poll();
        send(24'h400300, 24, "t3_poll", 0, 0, 0);
        send(24'h400300, 24, "t4_ignored_start", 10, 0, 0);
        send(24'h400300, 31, "t6_clamp", 0, 0, 0);
    endtask

    task automatic test_enable();
        enable = 1'b0;
        tx_data = 24'hFFFFFF;
        tx_len = LEN_W'(8);
        start = 1'b1;
        idle_cycles(40, "t6_enable_off");
        enable = 1'b1;
        send(24'hA5C300, 16, "enable_drop_mid", 0, 1, 0);
    endtask

    task automatic test_mid_reset();
        int bad;
        bad = 0;
        tx_data = 24'h400300;
        tx_len  = LEN_W'(24);
        enable  = 1'b1;
        start   = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            start = (k == 30) ? 1'b1 : 1'b0;
            rst   = (k == 30);
        end
        @(negedge clk);
        checks++;
        if (drive_low !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_reset_cycle31: drive_low=%b busy=%b, expected 0 0", drive_low, busy);
        end
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t5_no_done: %0d cycles active after reset, expected 0", bad);
        end
        @(posedge clk); #1;
        send(24'h400300, 24, "t5_after_reset", 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        send(24'h123456, 5, "b2b_a", 0, 0, 1);
        send(24'hF0F0F0, 3, "b2b_b", 0, 0, 0);
        for (int i = 0; i < 8; i++)
            send(DW'($urandom), $urandom_range(0, 31), "random", 0, ($urandom_range(0, 3) == 0), 0);
    endtask

    initial begin
        test_reset();
        test_single_bits();
        test_poll();
        test_enable();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
